// File: rtl/a2d_chnl_sched_if.sv
// Signal bundle between the A2D channel scheduler, its SPI master and its consumers.
// The master modport is the scheduler; the slave modport is everything around it.
interface a2d_chnl_sched_if;
  logic        en;
  logic [7:0]  chnl_mask;
  logic        done;
  logic [15:0] rd_data;
  logic [2:0]  rd_chnl;
  logic        wrt;
  logic [15:0] cmd;
  logic        res_vld;
  logic [2:0]  res_chnl;
  logic [11:0] res;
  logic [11:0] rd_val;
  logic        busy;

  modport master (
    input  en, chnl_mask, done, rd_data, rd_chnl,
    output wrt, cmd, res_vld, res_chnl, res, rd_val, busy
  );

  modport slave (
    output en, chnl_mask, done, rd_data, rd_chnl,
    input  wrt, cmd, res_vld, res_chnl, res, rd_val, busy
  );
endinterface

// File: rtl/a2d_chnl_sched.sv
// Round-robin LTC2308 channel scheduler: issues SPI commands over the enabled channels,
// realigns the one-transaction result latency and keeps the latest reading per channel.
module a2d_chnl_sched #(
  parameter int GAP = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  a2d_chnl_sched_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_GAP} state_e;

  localparam logic [11:0] GAP_LAST = 12'(GAP - 1);

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [2:0]  prev_ch_q, prev_ch_d;
  logic        prev_vld_q, prev_vld_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        res_vld_q, res_vld_d;
  logic [2:0]  res_chnl_q, res_chnl_d;
  logic [11:0] res_q, res_d;
  logic        hold_we;
  logic [11:0] hold_q [8];
  logic [2:0]  sel_ch;
  logic        run_ok;
  logic        unused_rd_lsb;

  assign run_ok        = bus.en && (bus.chnl_mask != 8'h00);
  assign unused_rd_lsb = ^bus.rd_data[3:0];

  // Single-ended, unipolar, no sleep.
  function automatic logic [15:0] cmd_of(input logic [2:0] ch);
    return {1'b1, ch[0], ch[2:1], 1'b1, 1'b0, 10'h000};
  endfunction

  // Search ptr+1 .. ptr+8 (ptr itself last); the nearest set bit wins.
  always_comb begin
    logic [2:0] idx;
    sel_ch = ptr_q;
    idx    = ptr_q;
    for (int i = 8; i >= 1; i--) begin
      idx = ptr_q + 3'(i);
      if (bus.chnl_mask[idx]) sel_ch = idx;
    end
  end

  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    prev_ch_d  = prev_ch_q;
    prev_vld_d = prev_vld_q;
    wrt_d      = 1'b0;
    cmd_d      = cmd_q;
    res_vld_d  = 1'b0;
    res_chnl_d = res_chnl_q;
    res_d      = res_q;
    hold_we    = 1'b0;

    case (state_q)
      S_IDLE: if (run_ok) state_d = S_ISSUE;
      S_ISSUE: begin
        ptr_d   = sel_ch;
        cmd_d   = cmd_of(sel_ch);
        wrt_d   = 1'b1;
        state_d = S_XFER;
      end
      S_XFER: if (bus.done) begin
        // Data returned now belongs to the channel commanded one transaction ago.
        if (prev_vld_q) begin
          hold_we    = 1'b1;
          res_d      = bus.rd_data[15:4];
          res_chnl_d = prev_ch_q;
          res_vld_d  = 1'b1;
        end
        prev_ch_d  = ptr_q;
        prev_vld_d = 1'b1;
        cnt_d      = '0;
        state_d    = run_ok ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) state_d = run_ok ? S_ISSUE : S_IDLE;
        else                   cnt_d   = cnt_q + 12'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // A restart must discard the first returned word, which was never commanded.
    if (state_d == S_IDLE) prev_vld_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ptr_q      <= 3'd7;
      prev_ch_q  <= '0;
      prev_vld_q <= 1'b0;
      wrt_q      <= 1'b0;
      cmd_q      <= 16'h8800;
      res_vld_q  <= 1'b0;
      res_chnl_q <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      prev_ch_q  <= prev_ch_d;
      prev_vld_q <= prev_vld_d;
      wrt_q      <= wrt_d;
      cmd_q      <= cmd_d;
      res_vld_q  <= res_vld_d;
      res_chnl_q <= res_chnl_d;
      res_q      <= res_d;
    end
  end

  // NOTE: the holding file is reset because consumers read it as a register file, and
  // a reset must visibly clear every stale reading; it stays a small flop array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) hold_q[i] <= '0;
    end else if (hold_we) begin
      hold_q[prev_ch_q] <= bus.rd_data[15:4];
    end
  end

  assign bus.wrt      = wrt_q;
  assign bus.cmd      = cmd_q;
  assign bus.res_vld  = res_vld_q;
  assign bus.res_chnl = res_chnl_q;
  assign bus.res      = res_q;
  assign bus.rd_val   = hold_q[bus.rd_chnl];
  assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_a2d_chnl_sched.sv
// Randomized bench for a2d_chnl_sched: a transaction-level model predicts commands and
// results into queues, and a negedge monitor compares whatever the DUT presents.
module tb_a2d_chnl_sched;
  localparam int GAP = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  a2d_chnl_sched_if bus ();

  a2d_chnl_sched #(.GAP(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] cmd; bit timed; } cmd_exp_t;
  typedef struct { logic [2:0] ch; logic [11:0] val; } res_exp_t;

  cmd_exp_t exp_cmd[$];
  res_exp_t exp_res[$];
  cmd_exp_t mon_c;
  res_exp_t mon_r;

  int n_checks  = 0;
  int n_pass    = 0;
  int cyc       = 0;
  int last_done = -100;

  // Reference model: which channel is on the wire, which one the returning data belongs to.
  int          mdl_ptr;
  int          mdl_cur;
  int          mdl_prev_ch;
  bit          mdl_prev_vld;
  logic [11:0] mdl_hold [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int next_ch(input int ptr, input logic [7:0] mask);
    for (int step = 1; step <= 8; step++) begin
      int c;
      c = (ptr + step) % 8;
      if (mask[3'(c)]) return c;
    end
    return ptr;
  endfunction

  function automatic logic [15:0] cmd_for(input int ch);
    int v;
    v = 'h8800 + (ch % 2) * 'h4000 + (ch / 2) * 'h1000;
    return v[15:0];
  endfunction

  function automatic void mdl_reset();
    mdl_ptr      = 7;
    mdl_cur      = 0;
    mdl_prev_ch  = 0;
    mdl_prev_vld = 1'b0;
    foreach (mdl_hold[i]) mdl_hold[i] = '0;
  endfunction

  function automatic void issue_next(input bit timed);
    cmd_exp_t e;
    mdl_ptr = next_ch(mdl_ptr, bus.chnl_mask);
    mdl_cur = mdl_ptr;
    e.cmd   = cmd_for(mdl_cur);
    e.timed = timed;
    exp_cmd.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: pops an expectation whenever the DUT presents wrt or res_vld.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) last_done = cyc;
      if (bus.wrt) begin
        if (exp_cmd.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_wrt: got wrt with cmd %h, expected no wrt", bus.cmd);
        end else begin
          mon_c = exp_cmd.pop_front();
          check("cmd", bus.cmd, mon_c.cmd);
          if (mon_c.timed) check("done_to_wrt", cyc - last_done, GAP + 2);
        end
      end
      if (bus.res_vld) begin
        if (exp_res.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_res_vld: got res %h ch %0d, expected no result",
                   bus.res, bus.res_chnl);
        end else begin
          mon_r = exp_res.pop_front();
          check("res", bus.res, mon_r.val);
          check("res_chnl", bus.res_chnl, mon_r.ch);
          check("done_to_res_vld", cyc - last_done, 1);
        end
      end
    end
  end

  task automatic wait_wrt(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.wrt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL wrt_timeout: got no wrt within 200 cycles, expected one");
    end
  endtask

  task automatic start_run(input logic [7:0] m);
    @(posedge clk); #1;
    bus.chnl_mask = m;
    issue_next(1'b0);
    bus.en = 1'b1;
  endtask

  // One SPI transaction: wait for wrt, optionally change mask/en mid-transfer, return done.
  task automatic do_xfer(input logic [7:0] mask_x, input bit en_x, input bit drop_gap,
                         input logic [15:0] data);
    bit          ok;
    bit          cont;
    logic [11:0] old_v;
    res_exp_t    r;
    wait_wrt(ok);
    if (!ok) return;
    @(posedge clk); #1;
    bus.chnl_mask = mask_x;
    bus.en        = en_x;
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    if (mdl_prev_vld) begin
      r.ch  = 3'(mdl_prev_ch);
      r.val = data[15:4];
      exp_res.push_back(r);
    end
    bus.rd_chnl = mdl_prev_vld ? 3'(mdl_prev_ch) : 3'($urandom_range(0, 7));
    old_v       = mdl_hold[bus.rd_chnl];
    bus.done    = 1'b1;
    bus.rd_data = data;
    @(negedge clk);
    check("rd_val_before_write", bus.rd_val, old_v);
    if (mdl_prev_vld) mdl_hold[mdl_prev_ch] = data[15:4];
    mdl_prev_ch  = mdl_cur;
    mdl_prev_vld = 1'b1;
    cont = bus.en && (bus.chnl_mask != 8'h00) && !drop_gap;
    if (cont) issue_next(1'b1);
    else      mdl_prev_vld = 1'b0;
    @(posedge clk); #1;
    bus.done    = 1'b0;
    bus.rd_data = 16'($urandom);
    @(negedge clk);
    check("rd_val_after_write", bus.rd_val, mdl_hold[bus.rd_chnl]);
    if (drop_gap) begin
      @(posedge clk); #1;
      bus.en = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by 2 ms, expected the bench to finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] m;
    bit         ok;

    bus.en = 1'b0; bus.chnl_mask = 8'h00; bus.done = 1'b0; bus.rd_data = '0; bus.rd_chnl = '0;
    mdl_reset();

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_wrt", bus.wrt, 0);
    check("rst_cmd", bus.cmd, 16'h8800);
    check("rst_res_vld", bus.res_vld, 0);
    check("rst_res_chnl", bus.res_chnl, 0);
    check("rst_res", bus.res, 0);
    check("rst_busy", bus.busy, 0);
    for (int i = 0; i < 8; i++) begin
      bus.rd_chnl = 3'(i); #1;
      check("rst_hold", bus.rd_val, 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;

    // Single channel 0; first done discarded, second captures ABC.
    start_run(8'h01);
    do_xfer(8'h01, 1'b1, 1'b0, 16'($urandom));
    do_xfer(8'h01, 1'b1, 1'b0, 16'hABC0);
    check("hold0_abc", mdl_hold[0] == 12'hABC, 1);

    // Round-robin over 8'hA5.
    do_xfer(8'hA5, 1'b1, 1'b0, 16'($urandom));
    repeat (5) do_xfer(8'hA5, 1'b1, 1'b0, 16'($urandom));

    // Mask switches 8'h0F -> 8'h80 while ch1 is in flight.
    do_xfer(8'h0F, 1'b1, 1'b0, 16'($urandom));
    for (int k = 0; k < 6 && mdl_cur != 1; k++) do_xfer(8'h0F, 1'b1, 1'b0, 16'($urandom));
    do_xfer(8'h80, 1'b1, 1'b0, 16'($urandom));
    repeat (2) do_xfer(8'h80, 1'b1, 1'b0, 16'($urandom));

    // en dropped during GAP, then resumed.
    do_xfer(8'h80, 1'b1, 1'b1, 16'($urandom));
    repeat (GAP + 10) @(negedge clk);
    check("busy_after_gap_drop", bus.busy, 0);
    start_run(8'h3C);
    repeat (3) do_xfer(8'h3C, 1'b1, 1'b0, 16'($urandom));

    // en dropped during XFER: transaction completes, then idle.
    do_xfer(8'h3C, 1'b0, 1'b0, 16'($urandom));
    repeat (GAP + 10) @(negedge clk);
    check("busy_after_xfer_drop", bus.busy, 0);

    // Randomized masks.
    m = 8'($urandom_range(1, 255));
    start_run(m);
    repeat (16) begin
      if ($urandom_range(0, 2) == 0) m = 8'($urandom_range(1, 255));
      do_xfer(m, 1'b1, 1'b0, 16'($urandom));
    end
    do_xfer(m, 1'b0, 1'b0, 16'($urandom));
    repeat (GAP + 10) @(negedge clk);

    // Reset in the middle of a transfer.
    start_run(8'h42);
    do_xfer(8'h42, 1'b1, 1'b0, 16'($urandom));
    do_xfer(8'h42, 1'b1, 1'b0, 16'($urandom));
    wait_wrt(ok);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    mdl_reset();
    exp_cmd.delete();
    exp_res.delete();
    #1;
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_res", bus.res, 0);
    for (int i = 0; i < 8; i++) begin
      bus.rd_chnl = 3'(i); #1;
      check("rst_mid_hold", bus.rd_val, 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    bus.done = 1'b1; bus.rd_data = 16'hFFF0;
    @(posedge clk); #1;
    bus.done = 1'b0;
    @(negedge clk);
    check("stray_done_res_vld", bus.res_vld, 0);
    check("stray_done_busy", bus.busy, 0);

    // Pointer restarts from 7 after reset.
    start_run(8'h42);
    repeat (2) do_xfer(8'h42, 1'b1, 1'b0, 16'($urandom));
    do_xfer(8'h42, 1'b0, 1'b0, 16'($urandom));
    repeat (GAP + 10) @(negedge clk);

    check("cmd_queue_drained", exp_cmd.size(), 0);
    check("res_queue_drained", exp_res.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
